// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential divider among NREQ requesters.
// Divide-by-zero is answered locally without starting the divider.
module div_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*WIDTH-1:0] i_dividend,
   input  logic [NREQ*WIDTH-1:0] i_divisor,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_done,
   output logic [WIDTH-1:0]      o_quotient,
   output logic [WIDTH-1:0]      o_remain,
   output logic                  o_dz,
   output logic                  o_busy,
   output logic                  o_div_start,
   output logic [WIDTH-1:0]      o_div_dividend,
   output logic [WIDTH-1:0]      o_div_divisor,
   input  logic                  i_div_ready,
   input  logic                  i_div_done,
   input  logic [WIDTH-1:0]      i_div_quotient,
   input  logic [WIDTH-1:0]      i_div_remain
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             start_q, start_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   int unsigned      win_idx;
   logic [WIDTH-1:0] win_dvd;
   logic [WIDTH-1:0] win_dvs;

   // Scan from the highest offset down so the lowest offset after last_q wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_idx   = 0;
      for (int i = NREQ; i >= 1; i--) begin
         win_idx = (int'(last_q) + i) % NREQ;
         if (i_req[win_idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(win_idx);
         end
      end
      win_dvd = i_dividend[int'(win_id)*WIDTH +: WIDTH];
      win_dvs = i_divisor[int'(win_id)*WIDTH +: WIDTH];
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      last_d  = last_q;
      gnt_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      case (state_q)
         S_IDLE: begin
            if (win_found && i_div_ready) begin
               id_d  = win_id;
               dvd_d = win_dvd;
               dvs_d = win_dvs;
               gnt_d = NREQ'(1) << win_id;
               if (win_dvs == '0) begin
                  quot_d  = '1;
                  rem_d   = win_dvd;
                  dz_d    = 1'b1;
                  done_d  = NREQ'(1) << win_id;
                  state_d = S_RESP;
               end else begin
                  start_d = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (i_div_done) begin
               quot_d  = i_div_quotient;
               rem_d   = i_div_remain;
               dz_d    = 1'b0;
               done_d  = NREQ'(1) << id_q;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            last_d  = id_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         last_q  <= IDW'(NREQ - 1);
         gnt_q   <= '0;
         done_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
      end
   end

   assign o_gnt          = gnt_q;
   assign o_done         = done_q;
   assign o_quotient     = quot_q;
   assign o_remain       = rem_q;
   assign o_dz           = dz_q;
   assign o_busy         = busy_q;
   assign o_div_start    = start_q;
   assign o_div_dividend = dvd_q;
   assign o_div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural WIDTH+2 cycle divider attached.
module tb_div_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] dvd, dvs;
   logic [NREQ-1:0]       o_gnt, o_done;
   logic [WIDTH-1:0]      o_quotient, o_remain, o_div_dividend, o_div_divisor;
   logic                  o_dz, o_busy, o_div_start;
   logic                  div_ready, div_done, model_ready, force_nr;
   logic [WIDTH-1:0]      div_q, div_r;
   logic [3:0]            dcnt;

   div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
      .i_dividend(dvd), .i_divisor(dvs),
      .o_gnt(o_gnt), .o_done(o_done), .o_quotient(o_quotient), .o_remain(o_remain),
      .o_dz(o_dz), .o_busy(o_busy), .o_div_start(o_div_start),
      .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
      .i_div_ready(div_ready), .i_div_done(div_done),
      .i_div_quotient(div_q), .i_div_remain(div_r)
   );

   // Divider model: start seen at edge of cycle G, done high in cycle G+10.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt  <= 4'd0;
         div_q <= '0;
         div_r <= '0;
      end else if (o_div_start && dcnt == 4'd0) begin
         dcnt  <= 4'(WIDTH + 2);
         div_q <= (o_div_divisor == 0) ? '0 : o_div_dividend / o_div_divisor;
         div_r <= (o_div_divisor == 0) ? '0 : o_div_dividend % o_div_divisor;
      end else if (dcnt != 4'd0) begin
         dcnt <= dcnt - 4'd1;
      end
   end
   assign model_ready = (dcnt == 4'd0);
   assign div_ready   = model_ready & ~force_nr;
   assign div_done    = (dcnt == 4'd1);

   typedef struct { logic [3:0] gnt; logic start; } gexp_t;
   typedef struct { logic [3:0] done; logic [7:0] q; logic [7:0] r; logic dz; int lat; } rexp_t;
   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t ge;
   rexp_t re;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int gnt_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a grant or a result.
   always @(negedge clk) begin
      if (o_gnt != 0) begin
         if (gq.size() == 0) fail("unexpected_gnt");
         else begin
            ge = gq.pop_front();
            chk("gnt", 64'(o_gnt), 64'(ge.gnt));
            chk("div_start", 64'(o_div_start), 64'(ge.start));
         end
         gnt_cyc = cyc;
      end else if (o_div_start) begin
         fail("div_start_without_gnt");
      end
      if (o_done != 0) begin
         if (rq.size() == 0) fail("unexpected_done");
         else begin
            re = rq.pop_front();
            chk("done", 64'(o_done), 64'(re.done));
            chk("quotient", 64'(o_quotient), 64'(re.q));
            chk("remain", 64'(o_remain), 64'(re.r));
            chk("dz", 64'(o_dz), 64'(re.dz));
            chk("latency", 64'(cyc - gnt_cyc), 64'(re.lat));
         end
      end
   end

   task automatic setop(input int k, input logic [7:0] a, input logic [7:0] b);
      dvd[k*WIDTH +: WIDTH] = a;
      dvs[k*WIDTH +: WIDTH] = b;
   endtask

   task automatic exp_g(input logic [3:0] g, input logic s);
      gq.push_back('{gnt: g, start: s});
   endtask

   task automatic exp_r(input logic [3:0] d, input logic [7:0] q, input logic [7:0] r,
                        input logic dz, input int lat);
      rq.push_back('{done: d, q: q, r: r, dz: dz, lat: lat});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      chk("reset_outputs",
          64'({o_gnt, o_done, o_quotient, o_remain, o_dz, o_busy, o_div_start,
               o_div_dividend, o_div_divisor}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Drive requests; drop each on its grant unless held, stop after n grants and idle.
   task automatic run(input logic [3:0] r, input bit hold, input int n, input int budget);
      int seen = 0;
      int t = 0;
      req = r;
      while ((seen < n || o_busy) && t < budget) begin
         @(negedge clk);
         t++;
         if (o_gnt != 0) begin
            seen++;
            if (seen == n) req = '0;
            else if (!hold) req = req & ~o_gnt;
         end
      end
      if (t >= budget) begin
         fail("run_timeout");
         req = '0;
      end
      @(negedge clk);
      chk("results_pending", 64'(rq.size()), 64'd0);
   endtask

   initial begin
      int t;
      req = '0; dvd = '0; dvs = '0; force_nr = 1'b0;
      do_reset();

      // 1: single request 100/7
      setop(0, 8'd100, 8'd7);
      exp_g(4'b0001, 1'b1);
      exp_r(4'b0001, 8'd14, 8'd2, 1'b0, 11);
      run(4'b0001, 1'b0, 1, 60);

      // 2: all four after reset, served 0,1,2,3
      do_reset();
      setop(0, 8'd200, 8'd3); setop(1, 8'd50, 8'd5);
      setop(2, 8'd9, 8'd10);  setop(3, 8'd255, 8'd16);
      exp_g(4'b0001, 1'b1); exp_r(4'b0001, 8'd66, 8'd2, 1'b0, 11);
      exp_g(4'b0010, 1'b1); exp_r(4'b0010, 8'd10, 8'd0, 1'b0, 11);
      exp_g(4'b0100, 1'b1); exp_r(4'b0100, 8'd0, 8'd9, 1'b0, 11);
      exp_g(4'b1000, 1'b1); exp_r(4'b1000, 8'd15, 8'd15, 1'b0, 11);
      run(4'b1111, 1'b0, 4, 200);

      // 3: req0 and req2 held, grants alternate
      setop(0, 8'd20, 8'd6); setop(2, 8'd9, 8'd4);
      for (int i = 0; i < 2; i++) begin
         exp_g(4'b0001, 1'b1); exp_r(4'b0001, 8'd3, 8'd2, 1'b0, 11);
         exp_g(4'b0100, 1'b1); exp_r(4'b0100, 8'd2, 8'd1, 1'b0, 11);
      end
      run(4'b0101, 1'b1, 4, 200);

      // 4: divide-by-zero answered locally
      setop(1, 8'd55, 8'd0);
      exp_g(4'b0010, 1'b0);
      exp_r(4'b0010, 8'hFF, 8'd55, 1'b1, 0);
      run(4'b0010, 1'b0, 1, 30);

      // 5: reset while waiting on the divider; aborted request gets no done
      setop(0, 8'd100, 8'd7);
      exp_g(4'b0001, 1'b1);
      req = 4'b0001;
      t = 0;
      while (o_gnt == 0 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) fail("gnt_timeout_t5");
      req = '0;
      repeat (3) @(negedge clk);
      chk("busy_in_wait", 64'(o_busy), 64'd1);
      do_reset();
      repeat (15) @(negedge clk);
      setop(3, 8'd200, 8'd9);
      exp_g(4'b1000, 1'b1);
      exp_r(4'b1000, 8'd22, 8'd2, 1'b0, 11);
      run(4'b1000, 1'b0, 1, 60);

      // 6: divider not ready blocks grants
      setop(0, 8'd7, 8'd2);
      force_nr = 1'b1;
      req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_gnt_not_ready", 64'(o_gnt), 64'd0);
      end
      exp_g(4'b0001, 1'b1);
      exp_r(4'b0001, 8'd3, 8'd1, 1'b0, 11);
      force_nr = 1'b0;
      @(negedge clk);
      chk("gnt_after_ready", 64'(o_gnt), 64'b0001);
      run(4'b0000, 1'b0, 0, 40);
      chk("grants_pending", 64'(gq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
